code_queue: RTL and testbench



---
 rtl/code_queue.sv | 192 +++++++++++++++++++
 tb/tb_code_queue.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_queue.sv
// code_queue -- byte-granular instruction prefetch queue.
//
// Fetches aligned FETCH_BYTES-wide words from the code bus into a DEPTH-byte
// circular buffer. The decoder sees a WIN_BYTES-wide window whose byte 0 is
// always the current instruction byte. The decoder retires a variable number
// of bytes each cycle. A flush restarts the queue at any byte address.
//
// Ports
//   clock          sole clock, rising edge
//   rst_n          asynchronous active-low reset
//   i_flush        restart queue at i_flush_addr (highest priority)
//   i_flush_addr   new linear code address, any alignment
//   o_fetch_req    fetch request, held until i_fetch_ack
//   o_fetch_addr   FETCH_BYTES-aligned fetch address, stable while requesting
//   i_fetch_ack    fetch complete this cycle, i_fetch_data valid
//   i_fetch_data   fetched word, lowest byte at o_fetch_addr
//   o_window       decoder window, byte k = queue byte k (0 beyond o_avail)
//   o_avail        valid bytes in queue (0..DEPTH)
//   o_head_addr    linear address of window byte 0
//   i_consume      bytes retired by the decoder this cycle
module code_queue #(
  parameter int FETCH_BYTES = 4,
  parameter int DEPTH       = 32,
  parameter int WIN_BYTES   = 16
) (
  input  logic                         clock,
  input  logic                         rst_n,
  input  logic                         i_flush,
  input  logic [31:0]                  i_flush_addr,
  output logic                         o_fetch_req,
  output logic [31:0]                  o_fetch_addr,
  input  logic                         i_fetch_ack,
  input  logic [FETCH_BYTES*8-1:0]     i_fetch_data,
  output logic [WIN_BYTES*8-1:0]       o_window,
  output logic [$clog2(DEPTH):0]       o_avail,
  output logic [31:0]                  o_head_addr,
  input  logic [$clog2(WIN_BYTES):0]   i_consume
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SKIP_W = (FETCH_BYTES > 1) ? $clog2(FETCH_BYTES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic [31:0]         fetch_addr_q, fetch_addr_d;
  logic [31:0]         target_q, target_d;
  logic [SKIP_W-1:0]   skip_q, skip_d;
  logic [31:0]         head_q, head_d;
  logic [PTR_W-1:0]    rd_q, rd_d;
  logic [PTR_W-1:0]    wr_q, wr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [7:0]          mem_q [DEPTH];

  logic                wr_en;
  logic [CNT_W-1:0]    cons_w;
  logic [CNT_W-1:0]    eff;
  logic [CNT_W-1:0]    written;
  logic [31:0]         flush_target;
  logic [SKIP_W-1:0]   flush_skip;

  assign cons_w       = CNT_W'(i_consume);
  assign eff          = (cons_w < count_q) ? cons_w : count_q;
  assign flush_target = i_flush_addr & ~32'(FETCH_BYTES - 1);
  assign flush_skip   = SKIP_W'(i_flush_addr & 32'(FETCH_BYTES - 1));

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    fetch_addr_d = fetch_addr_q;
    target_d     = target_q;
    skip_d       = skip_q;
    head_d       = head_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    count_d      = count_q;
    wr_en        = 1'b0;
    written      = '0;

    if (i_flush) begin
      count_d  = '0;
      rd_d     = '0;
      wr_d     = '0;
      head_d   = i_flush_addr;
      target_d = flush_target;
      skip_d   = flush_skip;
      // An un-acked request already on the bus must complete before the new
      // target can be issued; its data will be dropped in STALE.
      if ((state_q == RUN && req_q && !i_fetch_ack) ||
          (state_q == STALE && !i_fetch_ack)) begin
        state_d = STALE;
      end else begin
        state_d      = RUN;
        fetch_addr_d = flush_target;
      end
      req_d = 1'b1;  // STALE holds the request; RUN starts empty so has space
    end else begin
      unique case (state_q)
        RUN: begin
          // Acks without an outstanding request are not ours to accept.
          if (i_fetch_ack && req_q) begin
            wr_en        = 1'b1;
            written      = CNT_W'(FETCH_BYTES) - CNT_W'(skip_q);
            wr_d         = wr_q + PTR_W'(written);
            skip_d       = '0;
            fetch_addr_d = fetch_addr_q + 32'(FETCH_BYTES);
          end
        end
        STALE: begin
          if (i_fetch_ack) begin
            fetch_addr_d = target_q;
            state_d      = RUN;
          end
        end
        default: ;
      endcase

      count_d = count_q + written - eff;
      rd_d    = rd_q + PTR_W'(eff);
      head_d  = head_q + 32'(eff);

      unique case (state_d)
        RUN:     req_d = (count_d <= CNT_W'(DEPTH - FETCH_BYTES));
        STALE:   req_d = 1'b1;
        default: req_d = 1'b0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      fetch_addr_q <= '0;
      target_q     <= '0;
      skip_q       <= '0;
      head_q       <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      fetch_addr_q <= fetch_addr_d;
      target_q     <= target_d;
      skip_q       <= skip_d;
      head_q       <= head_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      count_q      <= count_d;
    end
  end

  // NOTE: the byte array has no reset; bytes at or beyond count are masked in
  // the window, so stale contents are never visible.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int j = 0; j < FETCH_BYTES; j++) begin
        // Leading bytes below the flush offset precede the target address.
        if (SKIP_W'(j) >= skip_q) begin
          mem_q[wr_q + PTR_W'(j) - PTR_W'(skip_q)] <= i_fetch_data[8*j +: 8];
        end
      end
    end
  end

  // Window is aligned to rd_ptr so the decoder needs no shifter.
  always_comb begin
    o_window = '0;
    for (int k = 0; k < WIN_BYTES; k++) begin
      if (CNT_W'(k) < count_q) begin
        o_window[8*k +: 8] = mem_q[rd_q + PTR_W'(k)];
      end
    end
  end

  assign o_fetch_req  = req_q;
  assign o_fetch_addr = fetch_addr_q;
  assign o_avail      = count_q;
  assign o_head_addr  = head_q;

endmodule

// File: tb/tb_code_queue.sv
// tb_code_queue -- self-checking bench for code_queue.
//
// A byte-queue reference model tracks the expected queue contents, head and
// fetch addresses; directed steps walk the key scenarios and a randomized
// phase exercises mixed flush / ack / consume traffic.
module tb_code_queue;

  localparam int FB    = 4;
  localparam int DEPTH = 32;
  localparam int WIN   = 16;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_STALE = 2;

  logic                        clock = 1'b0;
  logic                        rst_n;
  logic                        i_flush;
  logic [31:0]                 i_flush_addr;
  logic                        o_fetch_req;
  logic [31:0]                 o_fetch_addr;
  logic                        i_fetch_ack;
  logic [FB*8-1:0]             i_fetch_data;
  logic [WIN*8-1:0]            o_window;
  logic [$clog2(DEPTH):0]      o_avail;
  logic [31:0]                 o_head_addr;
  logic [$clog2(WIN):0]        i_consume;

  code_queue #(
    .FETCH_BYTES (FB),
    .DEPTH       (DEPTH),
    .WIN_BYTES   (WIN)
  ) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .i_flush      (i_flush),
    .i_flush_addr (i_flush_addr),
    .o_fetch_req  (o_fetch_req),
    .o_fetch_addr (o_fetch_addr),
    .i_fetch_ack  (i_fetch_ack),
    .i_fetch_data (i_fetch_data),
    .o_window     (o_window),
    .o_avail      (o_avail),
    .o_head_addr  (o_head_addr),
    .i_consume    (i_consume)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  byte unsigned mq[$];
  int           m_mode;
  logic [31:0]  m_head;
  logic [31:0]  m_faddr;
  logic [31:0]  m_target;
  int           m_skip;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte stored at a code address: a fixed pattern so window bytes can be
  // predicted from their linear address alone.
  function automatic logic [7:0] code_byte(input logic [31:0] addr);
    return addr[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [FB*8-1:0] word_at(input logic [31:0] addr);
    logic [FB*8-1:0] w;
    for (int j = 0; j < FB; j++) w[8*j +: 8] = code_byte(addr + 32'(j));
    return w;
  endfunction

  function automatic bit m_req();
    if (m_mode == M_RUN)   return (DEPTH - mq.size()) >= FB;
    if (m_mode == M_STALE) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [WIN*8-1:0] m_window();
    logic [WIN*8-1:0] w;
    w = '0;
    for (int k = 0; k < WIN; k++) if (k < mq.size()) w[8*k +: 8] = mq[k];
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_mode   = M_IDLE;
    m_head   = '0;
    m_faddr  = '0;
    m_target = '0;
    m_skip   = 0;
  endtask

  // Advance the model by one clock with the given inputs.
  task automatic model_step(input bit fl, input logic [31:0] fa, input bit ack,
                            input logic [FB*8-1:0] data, input int cons);
    bit req;
    int eff;
    req = m_req();
    if (fl) begin
      if ((m_mode == M_RUN && req && !ack) || (m_mode == M_STALE && !ack)) begin
        m_mode = M_STALE;
      end else begin
        m_mode  = M_RUN;
        m_faddr = fa - (fa % FB);
      end
      m_target = fa - (fa % FB);
      m_skip   = int'(fa % FB);
      mq.delete();
      m_head = fa;
    end else begin
      eff = (cons < mq.size()) ? cons : mq.size();
      for (int i = 0; i < eff; i++) void'(mq.pop_front());
      m_head = m_head + 32'(eff);
      if (m_mode == M_RUN && ack && req) begin
        for (int j = m_skip; j < FB; j++) mq.push_back(data[8*j +: 8]);
        m_faddr = m_faddr + 32'(FB);
        m_skip  = 0;
      end else if (m_mode == M_STALE && ack) begin
        m_mode  = M_RUN;
        m_faddr = m_target;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".req"},    o_fetch_req,  m_req());
    check({tag, ".faddr"},  o_fetch_addr, m_faddr);
    check({tag, ".avail"},  o_avail,      mq.size());
    check({tag, ".head"},   o_head_addr,  m_head);
    check({tag, ".window"}, o_window,     m_window());
  endtask

  // Drive one cycle from a falling edge, sample #1 after the rising edge,
  // then return on the next falling edge.
  task automatic step(input bit fl, input logic [31:0] fa, input bit ack,
                      input logic [FB*8-1:0] data, input int cons, input string tag);
    i_flush      = fl;
    i_flush_addr = fa;
    i_fetch_ack  = ack;
    i_fetch_data = data;
    i_consume    = ($clog2(WIN)+1)'(cons);
    model_step(fl, fa, ack, data, cons);
    @(posedge clock);
    #1;
    compare_model(tag);
    @(negedge clock);
    i_flush     = 1'b0;
    i_fetch_ack = 1'b0;
    i_consume   = '0;
  endtask

  initial begin
    rst_n        = 1'b0;
    i_flush      = 1'b0;
    i_flush_addr = '0;
    i_fetch_ack  = 1'b0;
    i_fetch_data = '0;
    i_consume    = '0;
    model_reset();
    repeat (2) @(negedge clock);

    // Reset state.
    check("rst.req",    o_fetch_req,  1'b0);
    check("rst.faddr",  o_fetch_addr, 32'h0);
    check("rst.avail",  o_avail,      0);
    check("rst.head",   o_head_addr,  32'h0);
    check("rst.window", o_window,     '0);
    rst_n = 1'b1;
    @(negedge clock);

    // Unaligned flush, first ack keeps only the upper bytes.
    step(1, 32'h0000_1002, 0, '0, 0, "fl1002");
    check("fl1002.req",   o_fetch_req,  1'b1);
    check("fl1002.faddr", o_fetch_addr, 32'h0000_1000);
    step(0, '0, 1, 32'h4433_2211, 0, "ack1000");
    check("ack1000.avail", o_avail,          2);
    check("ack1000.win",   o_window[15:0],   16'h4433);
    check("ack1000.head",  o_head_addr,      32'h0000_1002);
    check("ack1000.faddr", o_fetch_addr,     32'h0000_1004);

    // Flush with ack in the same cycle, then fill the buffer to full.
    step(1, 32'h0000_2000, 1, 32'hDEAD_BEEF, 0, "fl2000");
    check("fl2000.avail", o_avail, 0);
    for (int i = 0; i < 8; i++) step(0, '0, 1, word_at(32'h2000 + 32'(4*i)), 0, "fill");
    check("full.avail", o_avail,     32);
    check("full.req",   o_fetch_req, 1'b0);
    step(0, '0, 0, '0, 4, "free4");
    check("free4.avail", o_avail,     28);
    check("free4.req",   o_fetch_req, 1'b1);

    // Build avail=5 then ack and consume 3 together.
    step(1, 32'h0000_5003, 1, '0, 0, "fl5003");
    step(0, '0, 1, word_at(32'h5000), 0, "ack5000");
    step(0, '0, 1, word_at(32'h5004), 0, "ack5004");
    check("five.avail", o_avail, 5);
    step(0, '0, 1, word_at(32'h5008), 3, "ackcons");
    check("ackcons.avail", o_avail,       6);
    check("ackcons.head",  o_head_addr,   32'h0000_5006);
    check("ackcons.byte0", o_window[7:0], code_byte(32'h5006));

    // Flush while a request is pending: old request completes and is dropped.
    step(1, 32'h0000_3001, 0, '0, 0, "fl3001");
    check("stale.req",   o_fetch_req,  1'b1);
    check("stale.faddr", o_fetch_addr, 32'h0000_500C);
    step(0, '0, 1, word_at(32'h500C), 0, "dropack");
    check("drop.avail", o_avail,      0);
    check("drop.faddr", o_fetch_addr, 32'h0000_3000);
    step(0, '0, 1, word_at(32'h3000), 0, "ack3000");
    check("ack3000.avail", o_avail, 3);

    // Flush coinciding with an ack discards the data.
    step(1, 32'h0000_4000, 1, 32'h1234_5678, 0, "fl4000");
    check("fl4000.avail", o_avail,      0);
    check("fl4000.faddr", o_fetch_addr, 32'h0000_4000);

    // Over-consume is clamped to what is available.
    step(1, 32'h0000_4003, 1, '0, 0, "fl4003");
    step(0, '0, 1, word_at(32'h4000), 0, "ack4000");
    step(0, '0, 1, word_at(32'h4004), 0, "ack4004");
    step(0, '0, 0, '0, 7, "over7");
    check("over7.avail", o_avail,     0);
    check("over7.head",  o_head_addr, 32'h0000_4008);
    check("over7.win",   o_window,    '0);

    // Address wrap at the top of the 32-bit space.
    step(1, 32'hFFFF_FFFE, 1, '0, 0, "flwrap");
    check("flwrap.faddr", o_fetch_addr, 32'hFFFF_FFFC);
    step(0, '0, 1, word_at(32'hFFFF_FFFC), 0, "ackwrap");
    check("wrap.faddr", o_fetch_addr, 32'h0000_0000);
    check("wrap.avail", o_avail,      2);
    step(0, '0, 0, '0, 2, "conswrap");
    check("conswrap.head", o_head_addr, 32'h0000_0000);

    // Reset mid-fetch clears immediately; a later ack in IDLE is ignored.
    step(1, 32'h0000_6000, 0, '0, 0, "fl6000");
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst.req",   o_fetch_req,  1'b0);
    check("midrst.faddr", o_fetch_addr, 32'h0);
    check("midrst.avail", o_avail,      0);
    @(negedge clock);
    rst_n = 1'b1;
    step(0, '0, 1, 32'hCAFE_F00D, 0, "idleack");
    check("idleack.avail", o_avail,     0);
    check("idleack.req",   o_fetch_req, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit          fl;
      bit          ack;
      int          cons;
      logic [31:0] fa;
      fl   = ($urandom_range(0, 24) == 0);
      fa   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : $urandom();
      ack  = m_req() && ($urandom_range(0, 2) != 0);
      cons = ($urandom_range(0, 3) == 0) ? $urandom_range(0, WIN) : 0;
      step(fl, fa, ack, FB*8'($urandom()), cons, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
